// File: rtl/eth_tx_arbiter_pkg.sv
// Shared definitions for the Ethernet TX arbiter.
//   state_e        : FSM state encoding (IDLE / SEND / GAP)
//   DEF_IFG_CYCLES : default inter-frame gap length in cycles
//   DEF_MAX_FRAME  : default byte limit before a frame is aborted
//   cnt_width()    : counter width able to hold 0..maxval (never 0 bits)
package eth_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEF_IFG_CYCLES = 12;
  localparam int DEF_MAX_FRAME  = 1518;

  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Bundle of the requester-side and MAC-side byte streams of the TX arbiter.
// Signal names are given from the arbiter's point of view.
//   i_req/i_wdata/i_wvalid/i_wlast : per-requester frame streams (byte k at [8k+7:8k])
//   o_gnt/o_wready                 : per-requester grant and ready
//   o_wdata/o_wvalid/i_wready      : muxed byte stream towards the MAC
// Modports: slave = arbiter, master = requesters + MAC model.
interface eth_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ-1:0]   o_gnt;
  logic [8*N_REQ-1:0] i_wdata;
  logic [N_REQ-1:0]   i_wvalid;
  logic [N_REQ-1:0]   i_wlast;
  logic [N_REQ-1:0]   o_wready;
  logic [7:0]         o_wdata;
  logic               o_wvalid;
  logic               i_wready;

  modport slave (
    input  i_req, i_wdata, i_wvalid, i_wlast, i_wready,
    output o_gnt, o_wready, o_wdata, o_wvalid
  );

  modport master (
    output i_req, i_wdata, i_wvalid, i_wlast, i_wready,
    input  o_gnt, o_wready, o_wdata, o_wvalid
  );
endinterface

// File: rtl/eth_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
//   req_i  : request vector
//   last_i : index granted last; search starts at last_i+1 and wraps
//   gnt_o  : one-hot winner (0 when nothing requested)
//   idx_o  : index of the winner
//   any_o  : at least one request present
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] k;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // i = N lands back on last_i itself, so a lone requester can win again.
    for (int i = 1; i <= N; i++) begin
      k = IW'((int'(last_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one Ethernet TX byte port
// between N_REQ engines, with a forced inter-frame gap.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : eth_tx_arbiter_if.slave (requester streams + MAC stream)
//   o_busy       : high in SEND and GAP
//   o_abort      : one-cycle pulse after a frame reaches MAX_FRAME without last
//   o_state_dbg  : current FSM state
// Handshake: a byte moves in a cycle where valid and ready are both high;
// valid must not depend on ready. Towards the MAC that is o_wvalid & i_wready,
// towards requester k it is i_wvalid[k] & o_wready[k]; both are the same event.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES,
  parameter int MAX_FRAME  = DEF_MAX_FRAME
) (
  input  logic                i_clk,
  input  logic                i_rst,
  eth_tx_arbiter_if.slave     bus,
  output logic                o_busy,
  output logic                o_abort,
  output state_e              o_state_dbg
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(MAX_FRAME);
  localparam int GW = cnt_width(IFG_CYCLES);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]     sel_q, sel_d;       // granted index, doubles as rr pointer
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              abort_q, abort_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  logic [7:0]        sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              xfer;
  logic [CW-1:0]     cnt_inc;

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req_i  (bus.i_req),
    .last_i (sel_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      sel_q      <= IW'(N_REQ - 1);
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    abort_d    = 1'b0;
    // Saturating increment: the counter never wraps back to a small value.
    cnt_inc    = (byte_cnt_q == CW'(MAX_FRAME)) ? byte_cnt_q : byte_cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_SEND;
          gnt_d      = pick_gnt;
          sel_d      = pick_idx;
          byte_cnt_d = '0;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          byte_cnt_d = cnt_inc;
          // wlast on the MAX_FRAME-th byte is a normal end, not an abort.
          if (sel_last || (cnt_inc == CW'(MAX_FRAME))) begin
            gnt_d   = '0;
            abort_d = !sel_last;
            if (IFG_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GW'(IFG_CYCLES - 1);
            end else begin
              state_d   = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: zero-latency mux from the granted requester
  always_comb begin
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    if (state_q == ST_SEND) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (sel_q == IW'(k)) begin
          sel_data  = bus.i_wdata[8*k +: 8];
          sel_valid = bus.i_wvalid[k];
          sel_last  = bus.i_wlast[k];
        end
      end
    end
    xfer = sel_valid & bus.i_wready;
  end

  // gnt_q is zero outside SEND, so ready is masked in IDLE and GAP.
  assign bus.o_gnt    = gnt_q;
  assign bus.o_wready = gnt_q & {N_REQ{bus.i_wready}};
  assign bus.o_wdata  = sel_data;
  assign bus.o_wvalid = sel_valid;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_abort      = abort_q;
  assign o_state_dbg  = state_q;

endmodule
